// File: rtl/rv_pkg.sv
// Shared constants for the fetch front end: widths, reset/bubble values and
// instruction field positions.
package rv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned RS1_LSB  = 15;
    localparam int unsigned RS2_LSB  = 20;
    localparam int unsigned RD_LSB   = 7;
    localparam int unsigned FIELD_W  = 5;

    localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/pc_gen.sv
// Program counter: reset, word-aligned redirect with misalign pulse, hold on
// stall or memory not ready, increment on advance.
module pc_gen
    import rv_pkg::*;
#(
    parameter int unsigned       XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = rv_pkg::RESET_PC
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            ready_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] pc_d, pc_q;
    logic            misalign_d, misalign_q;

    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (flush_i) begin
            // Low bits are dropped; the pulse tells EX the target was bad.
            pc_d       = {target_i[XLEN-1:2], 2'b00};
            misalign_d = |target_i[1:0];
        end else if (!stall_i && ready_i) begin
            pc_d = pc_q + XLEN'(PC_INC);
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign misalign_o = misalign_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: drives instruction-memory requests from pc_gen and holds
// the IF/ID register with its register-specifier field slices.
module if_id_stage
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN      = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            imem_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] fetch_pc;

    logic [XLEN-1:0] instr_d, instr_q;
    logic [XLEN-1:0] pc_id_d, pc_id_q;
    logic            valid_d, valid_q;

    pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .ready_i    (imem_ready_i),
        .target_i   (target_i),
        .pc_o       (fetch_pc),
        .misalign_o (misalign_o)
    );

    assign imem_addr_o = fetch_pc;
    assign imem_req_o  = rst_n & ~stall_i & ~flush_i;

    always_comb begin
        instr_d = instr_q;
        pc_id_d = pc_id_q;
        valid_d = valid_q;
        if (flush_i) begin
            // Squash; pc_id is left as-is since a bubble carries no PC.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall_i) begin
            instr_d = instr_q;
        end else if (!imem_ready_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            instr_d = imem_rdata_i;
            pc_id_d = fetch_pc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_id_q <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_id_q <= pc_id_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_id_q;
    assign valid_o    = valid_q;
    assign pc_plus4_o = pc_id_q + XLEN'(PC_INC);

    assign rs1_o = instr_q[RS1_LSB +: FIELD_W];
    assign rs2_o = instr_q[RS2_LSB +: FIELD_W];
    assign rd_o  = instr_q[RD_LSB  +: FIELD_W];

endmodule
